// File: rtl/ctrl_clkgen.sv
// ctrl_clkgen: qualifies PLL lock over a hold-off, sequences a synchronous
// downstream reset and drives CHANNELS phase-aligned clock-enable strobes,
// each with a runtime-programmable divider (ratio = div+1).
// Optional feature macro: CTRL_CLK_SYNCLOAD_EN -- divider writes go to a
// shadow register and reach the active divider only at the channel's wrap.

// One divider channel: active divider, optional shadow, wrap counter, strobe.
module ctrl_clkgen_lane #(
    parameter int DIV_W    = 8,
    parameter int DIV_INIT = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             hold,   // registered rst_out: writes land immediately
    input  logic             clr,    // counter held at zero (reset out now or next)
    input  logic             we,
    input  logic [DIV_W-1:0] val,
    output logic             ce
);
    logic [DIV_W-1:0] cnt;
    logic [DIV_W-1:0] act;
    logic             wrap;
    logic             restart;

    assign wrap = !clr && (cnt == act);

`ifdef CTRL_CLK_SYNCLOAD_EN
    logic [DIV_W-1:0] shd;

    // Shadowed divider: active value only changes on a wrap, so no period is cut short
    always_ff @(posedge clk) begin
        if (rst) begin
            act <= DIV_W'(DIV_INIT);
            shd <= DIV_W'(DIV_INIT);
        end else if (we && hold) begin
            act <= val;
            shd <= val;
        end else begin
            if (we)   shd <= val;
            if (wrap) act <= shd;
        end
    end

    assign restart = 1'b0;
`else
    // Direct divider: a write takes effect at once and restarts the period
    always_ff @(posedge clk) begin
        if (rst)     act <= DIV_W'(DIV_INIT);
        else if (we) act <= val;
    end

    assign restart = we;
`endif

    // Wrap counter: one-cycle strobe each time cnt reaches the active divider
    always_ff @(posedge clk) begin
        if (rst || clr || restart) begin
            cnt <= '0;
            ce  <= 1'b0;
        end else if (cnt == act) begin
            cnt <= '0;
            ce  <= 1'b1;
        end else begin
            cnt <= cnt + 1'b1;
            ce  <= 1'b0;
        end
    end
endmodule

module ctrl_clkgen #(
    parameter int CHANNELS = 3,
    parameter int DIV_W    = 8,
    parameter int DIV_INIT = 0,
    parameter int LOCK_CYC = 1024,
    localparam int SEL_W   = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
    localparam int HC_W    = (LOCK_CYC > 1) ? $clog2(LOCK_CYC) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                pll_locked,
    input  logic                div_we,
    input  logic [SEL_W-1:0]    div_sel,
    input  logic [DIV_W-1:0]    div_val,
    output logic [CHANNELS-1:0] ce,
    output logic                rst_out,
    output logic                locked_out
);
    typedef enum logic [1:0] {S_WAIT, S_COUNT, S_RUN} state_t;

    state_t          st, st_nxt;
    logic [HC_W-1:0] hcnt, hcnt_nxt;
    logic            lk_m, lk_s;
    logic            clr;
    logic            sel_ok;

    // Two-flop synchroniser for the asynchronous PLL lock flag
    always_ff @(posedge clk) begin
        if (rst) begin
            lk_m <= 1'b0;
            lk_s <= 1'b0;
        end else begin
            lk_m <= pll_locked;
            lk_s <= lk_m;
        end
    end

    // State, hold counter and registered reset/lock outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            st         <= S_WAIT;
            hcnt       <= '0;
            rst_out    <= 1'b1;
            locked_out <= 1'b0;
        end else begin
            st         <= st_nxt;
            hcnt       <= hcnt_nxt;
            rst_out    <= (st_nxt != S_RUN);
            locked_out <= (st_nxt == S_RUN);
        end
    end

    // Next state. hcnt counts qualified lk_s cycles including the one seen
    // in WAIT, so reset releases exactly LOCK_CYC cycles after lk_s rises.
    always_comb begin
        st_nxt   = st;
        hcnt_nxt = hcnt;
        case (st)
            S_WAIT: begin
                hcnt_nxt = '0;
                if (lk_s) begin
                    if (LOCK_CYC == 1) begin
                        st_nxt = S_RUN;
                    end else begin
                        st_nxt   = S_COUNT;
                        hcnt_nxt = HC_W'(1);
                    end
                end
            end
            S_COUNT: begin
                if (!lk_s) begin
                    st_nxt   = S_WAIT;
                    hcnt_nxt = '0;
                end else if (hcnt == HC_W'(LOCK_CYC - 1)) begin
                    st_nxt   = S_RUN;
                    hcnt_nxt = '0;
                end else begin
                    hcnt_nxt = hcnt + 1'b1;
                end
            end
            S_RUN: begin
                if (!lk_s) st_nxt = S_WAIT;
            end
            default: begin
                st_nxt   = S_WAIT;
                hcnt_nxt = '0;
            end
        endcase
    end

    // Counters clear on the edge that enters reset as well as while in it,
    // so the strobes drop together with rst_out on loss of lock.
    assign clr    = rst_out || (st_nxt != S_RUN);
    assign sel_ok = ({1'b0, div_sel} < (SEL_W + 1)'(CHANNELS));

    for (genvar i = 0; i < CHANNELS; i++) begin : g_lane
        ctrl_clkgen_lane #(
            .DIV_W    (DIV_W),
            .DIV_INIT (DIV_INIT)
        ) u_lane (
            .clk  (clk),
            .rst  (rst),
            .hold (rst_out),
            .clr  (clr),
            .we   (div_we && sel_ok && (div_sel == SEL_W'(i))),
            .val  (div_val),
            .ce   (ce[i])
        );
    end
endmodule

// File: doc/ctrl_clkgen.md
# ctrl_clkgen

Parametrised clock-enable and reset-sequencing generator for the control subsystem. It takes the single system clock plus the raw PLL lock flag, qualifies lock over a programmable hold-off, then releases a synchronous reset and drives CHANNELS phase-aligned clock-enable strobes. Each strobe has a runtime-programmable divider. It replaces fixed multi-output PLL taps wherever a derived rate can be expressed as an enable on `clk`.

## Interface
- CHANNELS, 3: number of clock-enable outputs (1..16).
- DIV_W, 8: divider register width; the division ratio is div+1.
- DIV_INIT, 0: reset value loaded into every channel's divider.
- LOCK_CYC, 1024: cycles the synchronised lock must stay high before reset release (≥1).
- clk  in  1  system clock; the only clock in the block.
- rst  in  1  synchronous, active-high reset.
- pll_locked  in  1  raw PLL lock, asynchronous to `clk`.
- div_we  in  1  divider write strobe.
- div_sel  in  $clog2(CHANNELS) (min 1)  target channel of the write.
- div_val  in  DIV_W  new divider value.
- ce  out  CHANNELS  one-cycle enable strobes.
- rst_out  out  1  synchronous reset to downstream logic.
- locked_out  out  1  qualified lock; equals ~rst_out.

## Operation
- `pll_locked` passes through a 2-flop synchroniser (`lk_s`). Both flops reset to 0.
- FSM states:
  - WAIT: reset state. Moves to COUNT when `lk_s`=1. The hold counter is cleared.
  - COUNT: the hold counter increments every cycle. It returns to WAIT, clearing the counter, when `lk_s`=0. It moves to RUN when the counter reaches LOCK_CYC-1 with `lk_s` still 1.
  - RUN: returns to WAIT when `lk_s`=0.
- Output decode:
  - `rst_out` is 1 in WAIT and COUNT and 0 in RUN.
  - `locked_out` = ~`rst_out`.
  - Both outputs are registered.
- Per-channel divider counter `cnt[i]` (DIV_W bits):
  - While `rst_out`=1: `cnt`=0 and `ce[i]`=0.
  - Otherwise each cycle: if `cnt`==`div_act[i]`, then `cnt`←0 and `ce[i]`←1; else `cnt`←`cnt`+1 and `ce[i]`←0.
  - All channels therefore start in phase at reset release.
- Divider writes:
  - When `div_we`=1 and `div_sel`<CHANNELS, `div_val` is written to channel `div_sel`.
  - When `div_sel`≥CHANNELS the write is ignored.
  - How the write is applied is set under Configuration.
  - While `rst_out`=1, a write always loads both `div_shd` and `div_act` immediately.
- A `div_act` value of 0 gives `ce` high every cycle. The maximum value 2^DIV_W−1 gives a period of 2^DIV_W cycles.
- Loss of lock at any point in RUN:
  - Returns the FSM to WAIT.
  - Reasserts `rst_out`.
  - Zeroes all counters and `ce`.
  - Divider registers keep their values.
- `rst`=1, mid-operation or not:
  - FSM goes to WAIT and both synchroniser flops clear.
  - `cnt` and `ce` clear, and all `div_act`/`div_shd` reload DIV_INIT.
- Reset values: `ce`=0, `rst_out`=1, `locked_out`=0.

## Timing
- `pll_locked` rising in cycle t produces `lk_s`=1 at t+2.
- `rst_out` falls at t+2+LOCK_CYC, provided `lk_s` held high throughout.
- A `lk_s` glitch low during COUNT restarts the full LOCK_CYC hold-off.
- `pll_locked` falling in RUN at cycle t: `rst_out`=1 and all `ce`=0 from cycle t+3.
- Counter start: let k be the first cycle with `rst_out`=0.
  - First `ce[i]` is high in cycle k+div_act[i]+1.
  - After that, `ce[i]` repeats every div_act[i]+1 cycles with a duty of exactly one cycle.
- Write effect timing: the write updates the register on the clock edge that samples `div_we`, and is visible to the compare in the next cycle.

## Configuration
- `CTRL_CLK_SYNCLOAD_EN` defined:
  - A write lands in `div_shd[i]`.
  - `div_act[i]`←`div_shd[i]` only in the cycle in which `cnt[i]` wraps, i.e. the cycle `cnt`==`div_act`.
  - No truncated or stretched period is ever emitted.
  - A write coincident with the wrap cycle takes effect at the following wrap.
- `CTRL_CLK_SYNCLOAD_EN` undefined:
  - No shadow register.
  - A write loads `div_act[i]` directly and clears `cnt[i]` in the same edge.
  - The next `ce[i]` comes div_val+1 cycles after the write edge.

## Test plan
- Lock hold-off: LOCK_CYC=16, raise `pll_locked` at cycle 10 → `rst_out` falls at cycle 28 and `locked_out` rises at cycle 28.
- Lock glitch: drop `pll_locked` for 1 cycle at hold-off cycle 8, then restore → `rst_out` stays 1 and the full 16-cycle hold-off restarts.
- Divider rates: DIV_INIT=0, then during reset write ch1=2 and ch2=4 → ch0 pulses every cycle, ch1 every 3 cycles, ch2 every 5 cycles, all first pulses aligned relative to k.
- Runtime write, ch1 running at div 2:
  - With the macro defined, write 5 mid-period → the current 3-cycle period completes, then 6-cycle periods follow.
  - With the macro undefined → the next `ce` comes 6 cycles after the write.
- Loss of lock in RUN → `rst_out`=1 and `ce`=0 within 3 cycles; re-lock → dividers are retained and phases realigned.
- Illegal `div_sel`=3 with CHANNELS=3 → no divider changes; `rst` mid-run → all `div_act` return to DIV_INIT and `rst_out`=1.
